// File: rtl/ex_store_buffer_if.sv
// Store-buffer interface: store commit port, load probe port, data-bus write port and status.
// The design uses the slave modport; the driving environment uses the master modport.
interface ex_store_buffer_if #(
  parameter int DEPTH = 4
) ();
  logic                     st_valid;
  logic [31:0]              st_addr;
  logic [3:0]               st_wen;
  logic [31:0]              st_wdata;
  logic                     st_ready;

  logic                     ld_valid;
  logic [31:0]              ld_addr;
  logic                     ld_hit;
  logic [31:0]              ld_data;
  logic                     ld_stallreq;

  logic                     bus_req;
  logic [31:0]              bus_addr;
  logic [3:0]               bus_wen;
  logic [31:0]              bus_wdata;
  logic                     bus_addr_ok;
  logic                     bus_data_ok;

  logic                     sb_empty;
  logic [$clog2(DEPTH):0]   sb_count;

  modport slave (
    input  st_valid, st_addr, st_wen, st_wdata,
    output st_ready,
    input  ld_valid, ld_addr,
    output ld_hit, ld_data, ld_stallreq,
    output bus_req, bus_addr, bus_wen, bus_wdata,
    input  bus_addr_ok, bus_data_ok,
    output sb_empty, sb_count
  );

  modport master (
    output st_valid, st_addr, st_wen, st_wdata,
    input  st_ready,
    output ld_valid, ld_addr,
    input  ld_hit, ld_data, ld_stallreq,
    input  bus_req, bus_addr, bus_wen, bus_wdata,
    output bus_addr_ok, bus_data_ok,
    input  sb_empty, sb_count
  );
endinterface

// File: rtl/ex_store_buffer.sv
// Committed-store buffer: circular FIFO with tail write-combining, youngest-match load
// forwarding and a three-state drain engine writing the head entry to the data bus.
module ex_store_buffer #(
  parameter int DEPTH    = 4,
  parameter int MERGE_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  ex_store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  logic [29:0]      word_r  [DEPTH];
  logic [3:0]       wen_r   [DEPTH];
  logic [31:0]      data_r  [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  state_t           state_r;

  state_t           state_s;
  logic             full_s;
  logic [PW-1:0]    last_idx_s;
  logic             in_flight_s;
  logic             merge_s;
  logic             push_s;
  logic             pop_s;
  logic [CW-1:0]    count_next_s;
  logic             found_s;
  logic [PW-1:0]    found_idx_s;
  logic [PW-1:0]    probe_idx_s;
  logic             unused_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  wen);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = wen[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
    end
    return res;
  endfunction

  assign unused_s = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

  // Push/merge/pop decisions; the head entry is in flight whenever the drain FSM is busy
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    last_idx_s  = tail_r - PTR_ONE;
    in_flight_s = (state_r != S_IDLE) && (last_idx_s == head_r);
    merge_s     = (MERGE_EN != 0) && sb.st_valid && (count_r != {CW{1'b0}}) && !in_flight_s &&
                  valid_r[last_idx_s] && (word_r[last_idx_s] == sb.st_addr[31:2]);
    push_s      = sb.st_valid && !full_s && !merge_s;
    pop_s       = ((state_r == S_REQ) && sb.bus_addr_ok && sb.bus_data_ok) ||
                  ((state_r == S_WAIT) && sb.bus_data_ok);
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Drain FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (count_r != {CW{1'b0}}) state_s = S_REQ;
        else                       state_s = S_IDLE;
      end
      S_REQ: begin
        if (sb.bus_addr_ok && sb.bus_data_ok)
          state_s = (count_next_s != {CW{1'b0}}) ? S_REQ : S_IDLE;
        else if (sb.bus_addr_ok)
          state_s = S_WAIT;
        else
          state_s = S_REQ;
      end
      S_WAIT: begin
        if (sb.bus_data_ok)
          state_s = (count_next_s != {CW{1'b0}}) ? S_REQ : S_IDLE;
        else
          state_s = S_WAIT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Pointers, occupancy, valid bits and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      state_r <= S_IDLE;
    end else begin
      if (push_s) begin
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_ONE;
      end
      count_r <= count_next_s;
      state_r <= state_s;
    end
  end

  // Entry payload storage; contents are qualified by valid_r so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      word_r[tail_r] <= sb.st_addr[31:2];
      wen_r[tail_r]  <= sb.st_wen;
      data_r[tail_r] <= sb.st_wdata;
    end else if (merge_s) begin
      wen_r[last_idx_s]  <= wen_r[last_idx_s] | sb.st_wen;
      data_r[last_idx_s] <= merge_bytes(data_r[last_idx_s], sb.st_wdata, sb.st_wen);
    end
  end

  // Load probe: walk oldest to youngest so the last match found is the youngest
  always_comb begin
    found_s     = 1'b0;
    found_idx_s = {PW{1'b0}};
    probe_idx_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      probe_idx_s = head_r + PW'(i);
      if (valid_r[probe_idx_s] && (word_r[probe_idx_s] == sb.ld_addr[31:2])) begin
        found_s     = 1'b1;
        found_idx_s = probe_idx_s;
      end
    end
  end

  // Forwarding outputs
  always_comb begin
    sb.ld_hit      = 1'b0;
    sb.ld_stallreq = 1'b0;
    sb.ld_data     = 32'h0000_0000;
    if (sb.ld_valid && found_s) begin
      if (wen_r[found_idx_s] == 4'b1111) begin
        sb.ld_hit  = 1'b1;
        sb.ld_data = data_r[found_idx_s];
      end else begin
        sb.ld_stallreq = 1'b1;
      end
    end else begin
      sb.ld_hit = 1'b0;
    end
  end

  // Bus and status outputs, derived from registered state only
  always_comb begin
    sb.bus_req   = 1'b0;
    sb.bus_addr  = 32'h0000_0000;
    sb.bus_wen   = 4'b0000;
    sb.bus_wdata = 32'h0000_0000;
    if (state_r == S_REQ) begin
      sb.bus_req   = 1'b1;
      sb.bus_addr  = {word_r[head_r], 2'b00};
      sb.bus_wen   = wen_r[head_r];
      sb.bus_wdata = data_r[head_r];
    end else begin
      sb.bus_req = 1'b0;
    end
    sb.st_ready = !full_s;
    sb.sb_empty = (count_r == {CW{1'b0}});
    sb.sb_count = count_r;
  end
endmodule
